// File: rtl/square_channel_gen.sv
// ---------------------------------------------------------------------------
// square_channel_gen
//
// A square-wave sound channel of the classic handheld style. It has a duty
// cycle generator, a length counter, a volume envelope and an optional
// frequency sweep. A frame sequencer (512 Hz) and a period timer (~1 MHz)
// provide its timing, and both are derived from the 33 MHz system clock.
//
// Ports
//   I_CLK_33MHZ  in   1  system clock, rising edge
//   I_RESET      in   1  synchronous active-high reset
//   I_REG_WE     in   1  one-cycle register write strobe
//   I_REG_ADDR   in   3  0=NRx0 sweep, 1=NRx1 duty/length, 2=NRx2 envelope,
//                        3=NRx3 freq low, 4=NRx4 freq high/control
//   I_REG_WDATA  in   8  register write data
//   O_ON         out  1  channel active
//   O_SAMPLE     out  4  current output level (registered)
//   O_VOLUME     out  4  current envelope volume
//   O_FREQ       out 11  current frequency {NRx4[2:0], NRx3}
// ---------------------------------------------------------------------------
module square_channel_gen #(
    parameter int HAS_SWEEP = 1,
    parameter int FRAME_DIV = 64453,
    parameter int FREQ_DIV  = 32
) (
    input  logic        I_CLK_33MHZ,
    input  logic        I_RESET,
    input  logic        I_REG_WE,
    input  logic [2:0]  I_REG_ADDR,
    input  logic [7:0]  I_REG_WDATA,
    output logic        O_ON,
    output logic [3:0]  O_SAMPLE,
    output logic [3:0]  O_VOLUME,
    output logic [10:0] O_FREQ
);

    localparam bit SWEEP_ON = (HAS_SWEEP != 0);
    localparam int FRAME_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int FREQ_W   = (FREQ_DIV > 1) ? $clog2(FREQ_DIV) : 1;
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_DIV - 1);
    localparam logic [FREQ_W-1:0]  FREQ_LAST  = FREQ_W'(FREQ_DIV - 1);

    // The sweep adds or subtracts (base >> shift) in 12 bits. Bit 11 set
    // means the result no longer fits the 11-bit frequency (overflow).
    function automatic logic [11:0] sweepCalc(input logic [10:0] base,
                                              input logic [2:0]  shift,
                                              input logic        negate);
        logic [11:0] wide;
        logic [11:0] delta;
        wide  = {1'b0, base};
        delta = wide >> shift;
        sweepCalc = negate ? (wide - delta) : (wide + delta);
    endfunction

    // Timing state
    logic [FRAME_W-1:0] frameCnt_q, frameCnt_d;
    logic [2:0]         frameStep_q, frameStep_d;
    logic [FREQ_W-1:0]  freqCnt_q, freqCnt_d;
    logic [11:0]        perTimer_q, perTimer_d;
    logic [2:0]         dutyPos_q, dutyPos_d;

    // Register file
    logic [6:0]         nr0_q, nr0_d;
    logic [1:0]         duty_q, duty_d;
    logic [7:0]         nr2_q, nr2_d;
    logic               lenEn_q, lenEn_d;
    logic [10:0]        freq_q, freq_d;

    // Channel state
    logic [6:0]         lenCnt_q, lenCnt_d;
    logic [2:0]         envCnt_q, envCnt_d;
    logic [3:0]         volume_q, volume_d;
    logic               on_q, on_d;
    logic [3:0]         sample_q, sample_d;
    logic [10:0]        shadow_q, shadow_d;
    logic [3:0]         sweepTimer_q, sweepTimer_d;
    logic               sweepEn_q, sweepEn_d;

    // Decoded helpers
    logic        wr0, wr1, wr2, wr3, wr4, trigger;
    logic        frameTick, freqTick;
    logic        lengthStep, sweepStep, envStep;
    logic        dacOn;
    logic [2:0]  sweepPeriod, sweepShift;
    logic        sweepNegate;
    logic [3:0]  sweepReload;
    logic [10:0] trigFreq;
    logic [11:0] sweepNew, sweepNew2, trigNew;
    logic [7:0]  dutyPattern;

    // Address decode and the frame-sequencer step pulses. A trigger, or a
    // write to a register that a unit depends on, suppresses that unit's
    // step in the same cycle so the write is never overwritten.
    always_comb begin
        wr0     = I_REG_WE && (I_REG_ADDR == 3'd0);
        wr1     = I_REG_WE && (I_REG_ADDR == 3'd1);
        wr2     = I_REG_WE && (I_REG_ADDR == 3'd2);
        wr3     = I_REG_WE && (I_REG_ADDR == 3'd3);
        wr4     = I_REG_WE && (I_REG_ADDR == 3'd4);
        trigger = wr4 && I_REG_WDATA[7];

        frameTick = (frameCnt_q == FRAME_LAST);
        freqTick  = (freqCnt_q == FREQ_LAST);

        lengthStep = frameTick && !frameStep_q[0] && !trigger && !wr1 && !wr4;
        sweepStep  = SWEEP_ON && frameTick && (frameStep_q[1:0] == 2'b10) &&
                     on_q && !trigger && !wr0 && !wr3 && !wr4;
        envStep    = frameTick && (frameStep_q == 3'd7) && on_q &&
                     !trigger && !wr2;

        dacOn       = (nr2_q[7:3] != 5'd0);
        sweepPeriod = nr0_q[6:4];
        sweepNegate = nr0_q[3];
        sweepShift  = nr0_q[2:0];
        sweepReload = (sweepPeriod == 3'd0) ? 4'd8 : {1'b0, sweepPeriod};

        // A trigger writes the high frequency bits in the same cycle, so
        // it must use the incoming bits rather than the stored ones.
        trigFreq  = {I_REG_WDATA[2:0], freq_q[7:0]};
        sweepNew  = sweepCalc(shadow_q, sweepShift, sweepNegate);
        sweepNew2 = sweepCalc(sweepNew[10:0], sweepShift, sweepNegate);
        trigNew   = sweepCalc(trigFreq, sweepShift, sweepNegate);

        // Bit n holds the level at duty position n.
        case (duty_q)
            2'b00:   dutyPattern = 8'b1000_0000;
            2'b01:   dutyPattern = 8'b1000_0001;
            2'b10:   dutyPattern = 8'b1110_0001;
            default: dutyPattern = 8'b0111_1110;
        endcase
    end

    // Next-state logic. The ordering of the blocks below matters: register
    // writes and unit steps come first, and the trigger comes last so that
    // it overrides everything it touches.
    always_comb begin
        frameCnt_d   = frameCnt_q;
        frameStep_d  = frameStep_q;
        freqCnt_d    = freqCnt_q;
        perTimer_d   = perTimer_q;
        dutyPos_d    = dutyPos_q;
        nr0_d        = nr0_q;
        duty_d       = duty_q;
        nr2_d        = nr2_q;
        lenEn_d      = lenEn_q;
        freq_d       = freq_q;
        lenCnt_d     = lenCnt_q;
        envCnt_d     = envCnt_q;
        volume_d     = volume_q;
        on_d         = on_q;
        shadow_d     = shadow_q;
        sweepTimer_d = sweepTimer_q;
        sweepEn_d    = sweepEn_q;

        // The dividers are free-running.
        frameCnt_d = frameTick ? '0 : frameCnt_q + FRAME_W'(1);
        if (frameTick) begin
            frameStep_d = frameStep_q + 3'd1;
        end
        freqCnt_d = freqTick ? '0 : freqCnt_q + FREQ_W'(1);

        // The period timer only runs while the channel is on, which keeps
        // the duty position still between a reset and the next trigger.
        // Frequency writes are picked up at the reload and not mid-period.
        if (on_q && freqTick) begin
            if (perTimer_q <= 12'd1) begin
                perTimer_d = 12'd2048 - {1'b0, freq_q};
                dutyPos_d  = dutyPos_q + 3'd1;
            end else begin
                perTimer_d = perTimer_q - 12'd1;
            end
        end

        if (wr0 && SWEEP_ON) begin
            nr0_d = I_REG_WDATA[6:0];
        end
        if (wr1) begin
            duty_d   = I_REG_WDATA[7:6];
            lenCnt_d = 7'd64 - {1'b0, I_REG_WDATA[5:0]};
        end
        if (wr2) begin
            nr2_d = I_REG_WDATA;
            if (I_REG_WDATA[7:3] == 5'd0) begin
                on_d = 1'b0;
            end
        end
        if (wr3) begin
            freq_d[7:0] = I_REG_WDATA;
        end
        if (wr4) begin
            freq_d[10:8] = I_REG_WDATA[2:0];
            lenEn_d      = I_REG_WDATA[6];
        end

        if (lengthStep && lenEn_q && (lenCnt_q != 7'd0)) begin
            lenCnt_d = lenCnt_q - 7'd1;
            if (lenCnt_q == 7'd1) begin
                on_d = 1'b0;
            end
        end

        if (envStep && (nr2_q[2:0] != 3'd0)) begin
            if (envCnt_q <= 3'd1) begin
                envCnt_d = nr2_q[2:0];
                if (nr2_q[3] && (volume_q != 4'd15)) begin
                    volume_d = volume_q + 4'd1;
                end else if (!nr2_q[3] && (volume_q != 4'd0)) begin
                    volume_d = volume_q - 4'd1;
                end
            end else begin
                envCnt_d = envCnt_q - 3'd1;
            end
        end

        // A successful sweep write is followed by a second overflow check
        // on the new value; that result is never written back.
        if (sweepStep) begin
            if (sweepTimer_q <= 4'd1) begin
                sweepTimer_d = sweepReload;
                if (sweepEn_q && (sweepPeriod != 3'd0)) begin
                    if (sweepNew > 12'd2047) begin
                        on_d = 1'b0;
                    end else if (sweepShift != 3'd0) begin
                        shadow_d = sweepNew[10:0];
                        freq_d   = sweepNew[10:0];
                        if (sweepNew2 > 12'd2047) begin
                            on_d = 1'b0;
                        end
                    end
                end
            end else begin
                sweepTimer_d = sweepTimer_q - 4'd1;
            end
        end

        if (trigger) begin
            on_d       = dacOn;
            volume_d   = nr2_q[7:4];
            envCnt_d   = nr2_q[2:0];
            perTimer_d = 12'd2048 - {1'b0, trigFreq};
            dutyPos_d  = dutyPos_q;
            if (lenCnt_q == 7'd0) begin
                lenCnt_d = 7'd64;
            end
            if (SWEEP_ON) begin
                shadow_d     = trigFreq;
                sweepTimer_d = sweepReload;
                sweepEn_d    = (sweepPeriod != 3'd0) || (sweepShift != 3'd0);
                if ((sweepShift != 3'd0) && (trigNew > 12'd2047)) begin
                    on_d = 1'b0;
                end
            end
        end
    end

    // The output level is registered from the current state, which gives
    // it one cycle of latency behind on/volume/duty position.
    always_comb begin
        sample_d = (on_q && dutyPattern[dutyPos_q]) ? volume_q : 4'd0;
    end

    // State register with synchronous reset.
    always_ff @(posedge I_CLK_33MHZ) begin
        if (I_RESET) begin
            frameCnt_q   <= '0;
            frameStep_q  <= 3'd0;
            freqCnt_q    <= '0;
            perTimer_q   <= 12'd0;
            dutyPos_q    <= 3'd0;
            nr0_q        <= 7'd0;
            duty_q       <= 2'd0;
            nr2_q        <= 8'd0;
            lenEn_q      <= 1'b0;
            freq_q       <= 11'd0;
            lenCnt_q     <= 7'd0;
            envCnt_q     <= 3'd0;
            volume_q     <= 4'd0;
            on_q         <= 1'b0;
            sample_q     <= 4'd0;
            shadow_q     <= 11'd0;
            sweepTimer_q <= 4'd0;
            sweepEn_q    <= 1'b0;
        end else begin
            frameCnt_q   <= frameCnt_d;
            frameStep_q  <= frameStep_d;
            freqCnt_q    <= freqCnt_d;
            perTimer_q   <= perTimer_d;
            dutyPos_q    <= dutyPos_d;
            nr0_q        <= nr0_d;
            duty_q       <= duty_d;
            nr2_q        <= nr2_d;
            lenEn_q      <= lenEn_d;
            freq_q       <= freq_d;
            lenCnt_q     <= lenCnt_d;
            envCnt_q     <= envCnt_d;
            volume_q     <= volume_d;
            on_q         <= on_d;
            sample_q     <= sample_d;
            shadow_q     <= shadow_d;
            sweepTimer_q <= sweepTimer_d;
            sweepEn_q    <= sweepEn_d;
        end
    end

    assign O_ON     = on_q;
    assign O_SAMPLE = sample_q;
    assign O_VOLUME = volume_q;
    assign O_FREQ   = freq_q;

endmodule

// File: tb/tb_square_channel_gen.sv
// ---------------------------------------------------------------------------
// tb_square_channel_gen
//
// Directed bench for square_channel_gen. The dividers are shortened so that
// a frame step lasts 50 clocks and a period tick lasts 2 clocks. Every
// scenario starts from a reset, and cyc counts the clocks since that reset
// was released. This lets each frame-sequencer event be placed at an exact
// cycle: frame step s is clocked on edge (s+1)*FRAME_DIV.
// ---------------------------------------------------------------------------
module tb_square_channel_gen;

    localparam int FRAME_DIV = 50;
    localparam int FREQ_DIV  = 2;

    logic        I_CLK_33MHZ = 1'b0;
    logic        I_RESET;
    logic        I_REG_WE;
    logic [2:0]  I_REG_ADDR;
    logic [7:0]  I_REG_WDATA;
    logic        O_ON;
    logic [3:0]  O_SAMPLE;
    logic [3:0]  O_VOLUME;
    logic [10:0] O_FREQ;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    square_channel_gen #(
        .HAS_SWEEP (1),
        .FRAME_DIV (FRAME_DIV),
        .FREQ_DIV  (FREQ_DIV)
    ) dut (
        .I_CLK_33MHZ (I_CLK_33MHZ),
        .I_RESET     (I_RESET),
        .I_REG_WE    (I_REG_WE),
        .I_REG_ADDR  (I_REG_ADDR),
        .I_REG_WDATA (I_REG_WDATA),
        .O_ON        (O_ON),
        .O_SAMPLE    (O_SAMPLE),
        .O_VOLUME    (O_VOLUME),
        .O_FREQ      (O_FREQ)
    );

    always #5 I_CLK_33MHZ = ~I_CLK_33MHZ;

    // Advance n clocks and sample 1 time unit after each rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge I_CLK_33MHZ);
            #1;
            cyc++;
        end
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) tick(1);
    endtask

    // One register write, taking effect on the next rising edge.
    task automatic applyStimulus(input logic [2:0] a, input logic [7:0] d);
        I_REG_ADDR  = a;
        I_REG_WDATA = d;
        I_REG_WE    = 1'b1;
        tick(1);
        I_REG_WE    = 1'b0;
    endtask

    task automatic doReset;
        I_RESET = 1'b1;
        tick(2);
        I_RESET = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset;
        doReset;
        compared++;
        if (O_ON !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_on: got %0d expected 0", O_ON);
        end
        compared++;
        if (O_SAMPLE !== 4'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_sample: got %0d expected 0", O_SAMPLE);
        end
        compared++;
        if (O_VOLUME !== 4'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_volume: got %0d expected 0", O_VOLUME);
        end
        compared++;
        if (O_FREQ !== 11'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_freq: got 0x%0h expected 0x0", O_FREQ);
        end
    endtask

    // Duty 10 at frequency 0x700: 256 period ticks per duty step, which is
    // 512 clocks here. Level per position 0..7 is 1,0,0,0,0,1,1,1.
    task automatic test_duty;
        logic [7:0] pat;
        logic [3:0] exp;
        int n;
        pat = 8'b1110_0001;
        doReset;
        applyStimulus(3'd2, 8'hF0);
        applyStimulus(3'd1, 8'h80);
        applyStimulus(3'd3, 8'h00);
        applyStimulus(3'd4, 8'h87);
        compared++;
        if (O_ON !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL duty_on: got %0d expected 1", O_ON);
        end
        compared++;
        if (O_FREQ !== 11'h700) begin
            mismatched++;
            $display("[TB] FAIL duty_freq: got 0x%0h expected 0x700", O_FREQ);
        end
        compared++;
        if (O_VOLUME !== 4'd15) begin
            mismatched++;
            $display("[TB] FAIL duty_volume: got %0d expected 15", O_VOLUME);
        end
        tick(1);
        compared++;
        if (O_SAMPLE !== 4'd15) begin
            mismatched++;
            $display("[TB] FAIL duty_first: got %0d expected 15", O_SAMPLE);
        end
        n = 0;
        while (O_SAMPLE !== 4'd0 && n < 1500) begin
            tick(1);
            n++;
        end
        compared++;
        if (O_SAMPLE !== 4'd0) begin
            mismatched++;
            $display("[TB] FAIL duty_fall_timeout: got %0d expected 0", O_SAMPLE);
        end
        // Low spans positions 1..4, so the rise comes exactly 4 steps later.
        n = 0;
        while (O_SAMPLE !== 4'd15 && n < 3000) begin
            tick(1);
            n++;
        end
        compared++;
        if (n !== 4 * 256 * FREQ_DIV) begin
            mismatched++;
            $display("[TB] FAIL duty_low_span: got %0d expected %0d", n, 4 * 256 * FREQ_DIV);
        end
        // Now at the start of position 5; sample mid-step from here on.
        tick(256);
        for (int k = 0; k < 8; k++) begin
            exp = pat[(5 + k) % 8] ? 4'd15 : 4'd0;
            compared++;
            if (O_SAMPLE !== exp) begin
                mismatched++;
                $display("[TB] FAIL duty_pos%0d: got %0d expected %0d", (5 + k) % 8, O_SAMPLE, exp);
            end
            tick(512);
        end
    endtask

    // Length 64-62=2. Length steps fall on edges 50 and 150, so the
    // channel must turn off on edge 150.
    task automatic test_length;
        doReset;
        applyStimulus(3'd2, 8'hF0);
        applyStimulus(3'd1, 8'h3E);
        applyStimulus(3'd4, 8'hC7);
        compared++;
        if (O_ON !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL length_trigger_on: got %0d expected 1", O_ON);
        end
        waitUntil(149);
        compared++;
        if (O_ON !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL length_first_step: got %0d expected 1", O_ON);
        end
        tick(1);
        compared++;
        if (O_ON !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL length_second_step: got %0d expected 0", O_ON);
        end
    endtask

    // Envelope steps fall on edges 400, 800, ... The volume decreases by 1
    // on each step, starting from 8.
    task automatic test_envelope;
        doReset;
        applyStimulus(3'd2, 8'h81);
        applyStimulus(3'd4, 8'h80);
        compared++;
        if (O_VOLUME !== 4'd8) begin
            mismatched++;
            $display("[TB] FAIL env_start: got %0d expected 8", O_VOLUME);
        end
        waitUntil(399);
        compared++;
        if (O_VOLUME !== 4'd8) begin
            mismatched++;
            $display("[TB] FAIL env_before_step: got %0d expected 8", O_VOLUME);
        end
        for (int k = 1; k <= 8; k++) begin
            waitUntil(8 * FRAME_DIV * k);
            compared++;
            if (O_VOLUME !== 4'(8 - k)) begin
                mismatched++;
                $display("[TB] FAIL env_step%0d: got %0d expected %0d", k, O_VOLUME, 8 - k);
            end
        end
        waitUntil(8 * FRAME_DIV * 11);
        compared++;
        if (O_VOLUME !== 4'd0) begin
            mismatched++;
            $display("[TB] FAIL env_floor: got %0d expected 0", O_VOLUME);
        end
        compared++;
        if (O_ON !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL env_still_on: got %0d expected 1", O_ON);
        end
    endtask

    // Sweep steps fall on edges 150 and 350.
    // Add: 0x400 -> 0x600, and the follow-up check (0x900) turns the channel off.
    // Subtract: 0x400 -> 0x200 -> 0x100, and the channel stays on.
    task automatic test_sweep;
        doReset;
        applyStimulus(3'd0, 8'h11);
        applyStimulus(3'd2, 8'hF0);
        applyStimulus(3'd3, 8'h00);
        applyStimulus(3'd4, 8'h84);
        compared++;
        if (O_ON !== 1'b1 || O_FREQ !== 11'h400) begin
            mismatched++;
            $display("[TB] FAIL sweep_trigger: got on=%0d freq=0x%0h expected on=1 freq=0x400", O_ON, O_FREQ);
        end
        waitUntil(149);
        compared++;
        if (O_FREQ !== 11'h400) begin
            mismatched++;
            $display("[TB] FAIL sweep_before: got 0x%0h expected 0x400", O_FREQ);
        end
        tick(1);
        compared++;
        if (O_FREQ !== 11'h600) begin
            mismatched++;
            $display("[TB] FAIL sweep_add_freq: got 0x%0h expected 0x600", O_FREQ);
        end
        compared++;
        if (O_ON !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL sweep_overflow_off: got %0d expected 0", O_ON);
        end

        doReset;
        applyStimulus(3'd0, 8'h19);
        applyStimulus(3'd2, 8'hF0);
        applyStimulus(3'd3, 8'h00);
        applyStimulus(3'd4, 8'h84);
        waitUntil(150);
        compared++;
        if (O_FREQ !== 11'h200 || O_ON !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL sweep_sub_first: got on=%0d freq=0x%0h expected on=1 freq=0x200", O_ON, O_FREQ);
        end
        waitUntil(350);
        compared++;
        if (O_FREQ !== 11'h100 || O_ON !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL sweep_sub_second: got on=%0d freq=0x%0h expected on=1 freq=0x100", O_ON, O_FREQ);
        end
    endtask

    task automatic test_dac_off;
        doReset;
        applyStimulus(3'd2, 8'hF0);
        applyStimulus(3'd4, 8'h80);
        compared++;
        if (O_ON !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL dac_playing: got %0d expected 1", O_ON);
        end
        applyStimulus(3'd2, 8'h00);
        compared++;
        if (O_ON !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL dac_write_off: got %0d expected 0", O_ON);
        end
        applyStimulus(3'd4, 8'h80);
        tick(1);
        compared++;
        if (O_ON !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL dac_trigger_blocked: got %0d expected 0", O_ON);
        end
    endtask

    // Play fast (one duty step per tick) so the duty position has moved off
    // 0, then reset. Restarting with duty 10 must begin at position 0 (high).
    task automatic test_reset_mid;
        doReset;
        applyStimulus(3'd2, 8'hF0);
        applyStimulus(3'd1, 8'h00);
        applyStimulus(3'd3, 8'hFF);
        applyStimulus(3'd4, 8'h87);
        tick(7);
        compared++;
        if (O_ON !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL mid_playing: got %0d expected 1", O_ON);
        end
        I_RESET = 1'b1;
        tick(1);
        compared++;
        if (O_ON !== 1'b0 || O_SAMPLE !== 4'd0 || O_VOLUME !== 4'd0 || O_FREQ !== 11'd0) begin
            mismatched++;
            $display("[TB] FAIL mid_reset_outputs: got on=%0d sample=%0d vol=%0d freq=0x%0h expected all 0",
                     O_ON, O_SAMPLE, O_VOLUME, O_FREQ);
        end
        I_RESET = 1'b0;
        cyc = 0;
        applyStimulus(3'd2, 8'hF0);
        applyStimulus(3'd1, 8'h80);
        applyStimulus(3'd3, 8'h00);
        applyStimulus(3'd4, 8'h87);
        tick(1);
        compared++;
        if (O_SAMPLE !== 4'd15) begin
            mismatched++;
            $display("[TB] FAIL mid_restart_pos0: got %0d expected 15", O_SAMPLE);
        end
        tick(100);
        compared++;
        if (O_SAMPLE !== 4'd15) begin
            mismatched++;
            $display("[TB] FAIL mid_restart_hold: got %0d expected 15", O_SAMPLE);
        end
    endtask

    initial begin
        I_RESET     = 1'b1;
        I_REG_WE    = 1'b0;
        I_REG_ADDR  = 3'd0;
        I_REG_WDATA = 8'd0;
        $display("[TB] square_channel_gen bench start");
        test_reset;
        test_duty;
        test_length;
        test_envelope;
        test_sweep;
        test_dac_off;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
